shift_rows_pipe: RTL and testbench
==================================

# shift_rows_pipe

Pipelined, parametrised Rijndael ShiftRows / InvShiftRows stage with a valid/ready stream interface. It covers block widths of Nb = 4, 6 or 8 columns and selects forward, inverse or bypass per beat. It sits between the SubBytes/InvSubBytes and MixColumns/AddRoundKey stages of the iterative encrypt/decrypt datapath. It replaces the fixed 128-bit combinational inverse permutation with a registered stage that the round controller can back-pressure.

## Interface
- NB, default 4: columns per state, legal values 4, 6, 8; state width W = 32·NB bits
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- in_data  input  W  state; byte k = r + 4c sits at bits [W-1-8k -: 8], so byte 0 is the MSB
- in_mode  input  2  00 forward, 01 inverse, 10/11 bypass (sampled with the beat)
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_data  output  W  permuted state, same byte ordering
- beat_cnt  output  16  count of beats transferred on the output, saturating

## Operation
- Shift offsets (C0..C3): (0,1,2,3) for NB = 4 and 6; (0,1,3,4) for NB = 8.
- Forward: out[r][c] = in[r][(c + Cr) mod NB].
- Inverse: out[r][c] = in[r][(c − Cr + NB) mod NB].
- Bypass: out = in.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Permutation is computed combinationally on in_data/in_mode and captured into the output register on the input transfer. The mode travels with its own beat only.
- Beats are never dropped, duplicated or reordered.
- out_data and out_valid remain stable while out_valid && !out_ready.
- beat_cnt increments by 1 on each output transfer and holds at 0xFFFF.
- in_data is ignored when !in_valid. Transfers in any cycle with rst high are ignored.
- NB not in {4, 6, 8} is an elaboration error.

## Timing
- Latency: a beat accepted in cycle n is presented on out_valid in cycle n+1.
- Throughput: 1 beat/cycle while out_ready is held high.
- Reset values: out_valid 0, out_data 0, beat_cnt 0, in_ready 1 (first cycle after rst deasserts; stage empty).
- Simultaneous input and output transfer in the same cycle when full: the new beat replaces the departing one, and there is no bubble.
- rst mid-stream: all held beats are discarded. The next cycle shows the reset values.
- Storage states: EMPTY, ONE (output register valid), TWO (output register plus skid entry; SKID_EN only).
- EMPTY→ONE on an input transfer.
- ONE→EMPTY on an output transfer with no input transfer.
- ONE→TWO on an input transfer with no output transfer (SKID_EN).
- TWO→ONE on an output transfer; the skid entry moves to the output register in that cycle.
- TWO never accepts input.

## Configuration
- SHIFT_ROWS_SKID_EN defined:
  - two-entry skid buffer
  - in_ready is a flop output, equal to !(state == TWO); no combinational out_ready→in_ready path
  - full throughput is retained under registered back-pressure
- SHIFT_ROWS_SKID_EN undefined:
  - single output register; states EMPTY/ONE only
  - in_ready = !out_valid || out_ready, which is combinational from out_ready
  - latency and throughput are otherwise identical

## Structure
- shift_rows_pkg holds:
  - mode encoding constants (MODE_FWD, MODE_INV, MODE_BYP)
  - the legal-NB check
  - a constant function shift_off(nb, r) returning Cr
- Sub-module shift_rows_perm is purely combinational. Parameter NB; ports state_in, mode, state_out. It is shared with any future unrolled round.
- shift_rows_pipe contains only the handshake, storage and counter.

## Test plan
- NB=4, forward, in_data = 000102030405060708090a0b0c0d0e0f → out_data = 00050a0f04090e03080d02070c01060b one cycle later; beat_cnt = 1.
- NB=4, inverse, same input → 000d0a0704010e0b0805020f0c090603; applying forward to this result returns the ramp.
- NB=8, forward, ramp 00..1f → first output word 00050e13. NB=8 inverse(forward(x)) = x for 1000 random states.
- Bypass: in_mode = 10 and 11 → out_data equals in_data. Mixed modes on back-to-back beats each take their own mode.
- Back-pressure:
  - random in_valid/out_ready over 10000 beats → scoreboard match, no loss or reorder, out_data stable while stalled
  - with SKID_EN, in_ready never depends combinationally on out_ready
- Reset with two beats held → out_valid 0, beat_cnt 0 next cycle; a beat accepted during rst never appears. Saturation: force 65536 transfers → beat_cnt stays 0xFFFF.

Source files
------------

// File: rtl/shift_rows_pkg.sv
// Shared constants and helpers for the ShiftRows / InvShiftRows stage.
// SHIFT_ROWS_SKID_EN selects the two-entry skid variant of shift_rows_pipe.
package shift_rows_pkg;

  localparam logic [1:0] MODE_FWD = 2'b00;
  localparam logic [1:0] MODE_INV = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic bit nb_legal(input int unsigned nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Row shift offset Cr; the wide block skips offset 2 on rows 2 and 3.
  function automatic int unsigned shift_off(input int unsigned nb, input int unsigned r);
    if ((nb == 8) && (r >= 2)) return r + 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows / bypass byte permutation.
// Byte k = r + 4c sits at bits [W-1-8k -: 8].
module shift_rows_perm
  import shift_rows_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic [32*NB-1:0] state_in,
  input  logic [1:0]       mode,
  output logic [32*NB-1:0] state_out
);

  localparam int unsigned W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_perm: NB must be 4, 6 or 8");
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned CR = shift_off(NB, r);
      localparam int unsigned KD = r + 4 * c;
      localparam int unsigned KF = r + 4 * ((c + CR) % NB);
      localparam int unsigned KI = r + 4 * ((c + NB - CR) % NB);

      assign state_out[W-1-8*KD -: 8] =
        (mode == MODE_FWD) ? state_in[W-1-8*KF -: 8] :
        (mode == MODE_INV) ? state_in[W-1-8*KI -: 8] :
                             state_in[W-1-8*KD -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows stage with valid/ready handshake and saturating beat counter.
// Define SHIFT_ROWS_SKID_EN for the skid variant with a registered in_ready.
module shift_rows_pipe
  import shift_rows_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [15:0]       beat_cnt
);

  localparam int unsigned W = 32 * NB;

  logic [W-1:0] perm_data;
  logic         in_xfer;
  logic         out_xfer;

  shift_rows_perm #(.NB(NB)) u_perm (
    .state_in  (in_data),
    .mode      (in_mode),
    .state_out (perm_data)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef SHIFT_ROWS_SKID_EN
  state_e       state;
  logic [W-1:0] skid_data;

  // Output register plus skid entry; in_ready is a flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_data  <= perm_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= perm_data;
          end else if (in_xfer) begin
            skid_data <= perm_data;
            in_ready  <= 1'b0;
            state     <= ST_TWO;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
`else
  // Single output register; out_valid doubles as the EMPTY/ONE state.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_xfer) begin
      out_data  <= perm_data;
      out_valid <= 1'b1;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= 16'd0;
    end else if (out_xfer && (beat_cnt != 16'hFFFF)) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe at NB=4 and NB=8 with random back-pressure.
// Expected states come from a byte-level reference model of the row rotations.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst4, rst8;
  logic         in_valid4, in_ready4, out_valid4;
  logic         out_ready4 = 1'b1;
  logic [127:0] in_data4, out_data4;
  logic [1:0]   in_mode4;
  logic [15:0]  beat_cnt4;
  logic         in_valid8, in_ready8, out_valid8;
  logic         out_ready8 = 1'b1;
  logic [255:0] in_data8, out_data8;
  logic [1:0]   in_mode8;
  logic [15:0]  beat_cnt8;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q4[$];
  logic [255:0] exp_q8[$];
  int rdy_mode4 = 0;
  int rdy_mode8 = 0;
  int xcnt4 = 0;
  int xcnt8 = 0;
  logic [127:0] last4, held4;
  logic [255:0] last8, held8;
  bit stall4 = 0;
  bit stall8 = 0;

  shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_mode(in_mode4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .beat_cnt(beat_cnt4)
  );

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_mode(in_mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .beat_cnt(beat_cnt8)
  );

  // Reference: rotate each row of the byte matrix by its table offset.
  function automatic logic [255:0] model(input int nb, input logic [255:0] x, input logic [1:0] m);
    int off[4];
    int w;
    int src;
    logic [7:0] b;
    logic [255:0] y;
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    w = 32 * nb;
    y = '0;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (m == 2'b00)      src = (c + off[r]) % nb;
        else if (m == 2'b01) src = (c - off[r] + nb) % nb;
        else                 src = c;
        b = 8'(x >> (w - 8 - 8 * (r + 4 * src)));
        y = y | (256'(b) << (w - 8 - 8 * (r + 4 * c)));
      end
    end
    return y;
  endfunction

  function automatic logic [15:0] sat(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Back-pressure generators: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode4)
      0:       out_ready4 = 1'b1;
      1:       out_ready4 = ($urandom_range(0, 99) < 70);
      default: out_ready4 = 1'b0;
    endcase
`ifdef SHIFT_ROWS_SKID_EN
    if (!rst4) begin
      logic r0;
      #1;
      r0 = in_ready4;
      out_ready4 = !out_ready4;
      #1;
      chk("in_ready_indep", 256'(in_ready4), 256'(r0));
      out_ready4 = !out_ready4;
    end
`endif
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode8)
      0:       out_ready8 = 1'b1;
      1:       out_ready8 = ($urandom_range(0, 99) < 70);
      default: out_ready8 = 1'b0;
    endcase
  end

  // Monitors: pop on every output transfer, check stall stability and the beat counter.
  always @(negedge clk) begin
    if (rst4) begin
      stall4 = 0;
      xcnt4 = 0;
    end else begin
      if (stall4) chk("stable4", {out_valid4, out_data4}, {1'b1, held4});
      chk("beat_cnt4", 256'(beat_cnt4), 256'(sat(xcnt4)));
      if (out_valid4 && out_ready4) begin
        if (exp_q4.size() == 0) begin
          errors++;
          $display("FAIL spurious4: got %h expected no beat", out_data4);
        end else begin
          chk("data4", {128'b0, out_data4}, exp_q4.pop_front());
        end
        last4 = out_data4;
        xcnt4++;
      end
      stall4 = out_valid4 && !out_ready4;
      held4 = out_data4;
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      stall8 = 0;
      xcnt8 = 0;
    end else begin
      if (stall8) chk("stable8", {out_valid8, out_data8}, {1'b1, held8});
      chk("beat_cnt8", 256'(beat_cnt8), 256'(sat(xcnt8)));
      if (out_valid8 && out_ready8) begin
        if (exp_q8.size() == 0) begin
          errors++;
          $display("FAIL spurious8: got %h expected no beat", out_data8);
        end else begin
          chk("data8", out_data8, exp_q8.pop_front());
        end
        last8 = out_data8;
        xcnt8++;
      end
      stall8 = out_valid8 && !out_ready8;
      held8 = out_data8;
    end
  end

  task automatic send4(input logic [127:0] d, input logic [1:0] m, input logic [127:0] e);
    int n = 0;
    @(posedge clk); #1;
    in_valid4 = 1'b1; in_data4 = d; in_mode4 = m;
    forever begin
      @(negedge clk);
      if (in_ready4) begin
        exp_q4.push_back({128'b0, e});
        break;
      end
      n++;
      if (n > 1000) begin
        errors++;
        $display("FAIL timeout4: got no in_ready expected acceptance");
        in_valid4 = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      in_data4 = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_mode4 = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic send8(input logic [255:0] d, input logic [1:0] m, input logic [255:0] e);
    int n = 0;
    @(posedge clk); #1;
    in_valid8 = 1'b1; in_data8 = d; in_mode8 = m;
    forever begin
      @(negedge clk);
      if (in_ready8) begin
        exp_q8.push_back(e);
        break;
      end
      n++;
      if (n > 1000) begin
        errors++;
        $display("FAIL timeout8: got no in_ready expected acceptance");
        in_valid8 = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle8(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid8 = 1'b0;
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run4();
    logic [127:0] ramp, fwdc, invc, d, e;
    logic [255:0] t;
    logic [1:0] m;
    int n;
    ramp = 128'h000102030405060708090a0b0c0d0e0f;
    fwdc = 128'h00050a0f04090e03080d02070c01060b;
    invc = 128'h000d0a0704010e0b0805020f0c090603;
    send4(ramp, 2'b00, fwdc);
    idle4(1);
    @(posedge clk); @(negedge clk);
    chk("fwd_ramp4", 256'(last4), 256'(fwdc));
    chk("beat_cnt_one", 256'(beat_cnt4), 256'(16'd1));
    // Mixed modes back to back, each beat uses its own mode.
    send4(ramp, 2'b01, invc);
    send4(invc, 2'b00, ramp);
    send4(ramp, 2'b10, ramp);
    send4(ramp, 2'b11, ramp);
    send4(ramp, 2'b00, fwdc);
    idle4(2);
    rdy_mode4 = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle4($urandom_range(1, 3));
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      m = 2'($urandom_range(0, 3));
      t = model(4, {128'b0, d}, m);
      e = t[127:0];
      send4(d, m, e);
    end
    idle4(1);
    rdy_mode4 = 0;
    n = 0;
    while (exp_q4.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain4", 256'(exp_q4.size()), 256'(0));
    // Fill the stage under stall, then reset with another beat presented.
    rdy_mode4 = 2;
    idle4(2);
    @(posedge clk); #1;
    in_valid4 = 1'b1; in_data4 = ramp; in_mode4 = 2'b00;
    @(posedge clk); #1;
    in_data4 = fwdc;
    @(posedge clk); #1;
    rst4 = 1'b1;
    in_data4 = invc;
    exp_q4.delete();
    @(posedge clk); #1;
    rst4 = 1'b0;
    in_valid4 = 1'b0;
    rdy_mode4 = 0;
    @(negedge clk);
    chk("rst_out_valid4", 256'(out_valid4), 256'(1'b0));
    chk("rst_beat_cnt4", 256'(beat_cnt4), 256'(16'd0));
    chk("rst_in_ready4", 256'(in_ready4), 256'(1'b1));
    chk("rst_out_data4", 256'(out_data4), 256'(0));
    idle4(6);
  endtask

  task automatic run8();
    logic [255:0] ramp, x, f;
    int n;
    for (int k = 0; k < 32; k++) ramp[255-8*k -: 8] = 8'(k);
    send8(ramp, 2'b00, model(8, ramp, 2'b00));
    idle8(1);
    @(posedge clk); @(negedge clk);
    chk("fwd_word0_8", 256'(last8[255:224]), 256'(32'h00050e13));
    rdy_mode8 = 1;
    for (int i = 0; i < 1000; i++) begin
      x = rand256();
      f = model(8, x, 2'b00);
      send8(x, 2'b00, f);
      send8(f, 2'b01, x);
    end
    rdy_mode8 = 0;
    for (int i = 0; i < 65540; i++) begin
      x = rand256();
      send8(x, 2'($urandom_range(2, 3)), x);
    end
    idle8(1);
    n = 0;
    while (exp_q8.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", 256'(exp_q8.size()), 256'(0));
    @(negedge clk);
    chk("saturate8", 256'(beat_cnt8), 256'(16'hFFFF));
  endtask

  initial begin
    rst4 = 1'b1; rst8 = 1'b1;
    in_valid4 = 1'b0; in_data4 = '0; in_mode4 = 2'b00;
    in_valid8 = 1'b0; in_data8 = '0; in_mode8 = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    chk("reset_out_valid4", 256'(out_valid4), 256'(1'b0));
    chk("reset_out_data4", 256'(out_data4), 256'(0));
    chk("reset_beat_cnt4", 256'(beat_cnt4), 256'(16'd0));
    chk("reset_in_ready4", 256'(in_ready4), 256'(1'b1));
    chk("reset_out_valid8", 256'(out_valid8), 256'(1'b0));
    chk("reset_out_data8", out_data8, 256'(0));
    chk("reset_beat_cnt8", 256'(beat_cnt8), 256'(16'd0));
    chk("reset_in_ready8", 256'(in_ready8), 256'(1'b1));
    fork
      run4();
      run8();
    join
    chk("final_q4", 256'(exp_q4.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
